afp3_fifo1024x004_ctl: RTL and testbench
========================================

Name: afp3_fifo1024x004_ctl

Overview:
- Controller and reader for the 1024x4 simple-dual-port block RAM used in the AFP.
- Drives the RAM write and read ports and absorbs its 1-cycle registered read latency with a 2-entry output buffer.
- Presents a first-word-fall-through valid/ready stream to downstream logic.
- Never issues a read to the address being written in the same cycle, so the RAM's undefined collision output is never consumed.

Parameters:
- AFULL_THRESH, 1000, almost_full asserts when RAM occupancy >= this value (range 1..1024).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  write request; accepted when full=0.
- push_data  in  4  data written on an accepted push.
- full  out  1  RAM occupancy == 1024.
- almost_full  out  1  RAM occupancy >= AFULL_THRESH.
- q_valid  out  1  head of FIFO is present on q_data.
- q_data  out  4  head entry.
- q_ready  in  1  consumer accepts head when q_valid & q_ready.
- count  out  11  total occupancy: RAM entries + in-flight read + output-buffer entries, 0..1026.
- ovfl_err  out  1  one-cycle pulse when push=1 and full=1.
- ram_wren  out  1  RAM write enable.
- ram_wrad  out  10  RAM write address.
- ram_data  out  4  RAM write data.
- ram_rden  out  1  RAM read enable.
- ram_rdad  out  10  RAM read address.
- ram_q  in  4  RAM read data, valid the cycle after ram_rden.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr and rd_ptr (11-bit, MSB is wrap bit) = 0; rd_inflight = 0; buffer empty.
  - Outputs: q_valid=0, q_data=0, full=0, almost_full=0, count=0, ovfl_err=0.
  - ram_wren=0 and ram_rden=0 while reset is high.
  - RAM contents are not cleared. A read in flight at reset is discarded.
- Write side:
  - ram_wren = push & ~full (combinational).
  - ram_wrad = wr_ptr[9:0]; ram_data = push_data.
  - wr_ptr increments on ram_wren.
  - push while full: no write, pointers unchanged, ovfl_err=1 on the following cycle.
- RAM occupancy:
  - ram_occ = wr_ptr - rd_ptr, 11-bit modulo arithmetic.
  - full = (ram_occ == 1024); almost_full = (ram_occ >= AFULL_THRESH).
  - Both are registered from next-state values, so they are exact in the cycle after the causing event.
- Read issue:
  - ram_rden = (ram_occ != 0) & (buf_cnt + rd_inflight - pop < 2), where pop = q_valid & q_ready.
  - ram_rdad = rd_ptr[9:0]. rd_ptr increments on ram_rden.
  - rd_inflight <= ram_rden.
  - A write issued in cycle N is never readable before cycle N+1, because ram_occ counts only committed writes.
- Collision freedom:
  - rd_ptr == wr_ptr in [9:0] implies empty (no read) or full (no write).
  - Therefore ram_rden & ram_wren & (ram_rdad == ram_wrad) is never true. The bench asserts this every cycle.
- Output buffer:
  - 2-entry in-order buffer; head entry drives q_data; q_valid = (buf_cnt != 0).
  - When rd_inflight=1, ram_q is captured into the buffer at the end of that cycle.
  - Capture and pop in the same cycle: the head shifts and the new entry lands behind any remaining entry. Order is preserved.
  - The buffer never overflows, guaranteed by the ram_rden credit rule.
  - q_data holds its value while q_valid=1 and q_ready=0.
- Latency: push accepted in cycle N with the FIFO empty gives ram_rden in N+1, capture at the end of N+2, and q_valid=1 in N+3.
- Throughput: 1 push and 1 pop per cycle sustained.
- Capacity: 1026 total. With no pops, the buffer absorbs 2 entries, so full asserts after the 1026th accepted push.
- count: registered; +1 per accepted push, -1 per pop; unchanged on simultaneous push and pop.
- Pointer wrap: address 1023 -> 0. The wrap bit distinguishes full from empty.

Test Plan:
1. Reset, push 4'hA once with q_ready=1 -> ram_wren in cycle 0, ram_rden cycle 1, q_valid=1 & q_data=4'hA in cycle 3, count 1 -> 0 after pop.
2. q_ready=0, push 1026 incrementing values (mod 16) -> almost_full after RAM occupancy reaches 1000, full=1 after the 1026th push, count=1026. The 1027th push gives no ram_wren, ovfl_err pulse, count stays 1026.
3. From full state, q_ready=1 continuously -> 1026 values popped in push order, one per cycle after the first, full drops the cycle after the first RAM read, q_valid=0 and count=0 at the end.
4. Simultaneous push/pop streaming of 3000 values with q_ready=1 -> pointers wrap twice, output equals input sequence, count stable, collision assertion never fires.
5. Random q_ready (50%) with random push bursts -> scoreboard match, q_data stable while stalled, buffer never exceeds 2 entries.
6. Assert reset in the cycle after ram_rden with 5 entries stored -> q_valid=0, count=0 immediately, no capture of in-flight ram_q. Next push 4'h3 appears as the first output in 3 cycles.

Source files
------------

// File: rtl/afp3_fifo1024x004_ctl.sv
// rtl/afp3_fifo1024x004_ctl.sv - FWFT controller for a 1024x4 simple-dual-port RAM with a 2-entry read buffer
module afp3_fifo1024x004_ctl #(
    parameter int AFULL_THRESH = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [3:0]  push_data,
    output logic        full,
    output logic        almost_full,
    output logic        q_valid,
    output logic [3:0]  q_data,
    input  logic        q_ready,
    output logic [10:0] count,
    output logic        ovfl_err,
    output logic        ram_wren,
    output logic [9:0]  ram_wrad,
    output logic [3:0]  ram_data,
    output logic        ram_rden,
    output logic [9:0]  ram_rdad,
    input  logic [3:0]  ram_q
);

    localparam logic [10:0] AFULL_TH = 11'(AFULL_THRESH);

    logic [10:0] wr_ptr;
    logic [10:0] rd_ptr;
    logic [10:0] wr_ptr_nxt;
    logic [10:0] rd_ptr_nxt;
    logic [10:0] ram_occ;
    logic [10:0] occ_nxt;
    logic [10:0] count_nxt;
    logic        rd_inflight;
    logic [1:0]  buf_cnt;
    logic [1:0]  buf_cnt_nxt;
    logic [3:0]  buf0;
    logic [3:0]  buf1;
    logic [3:0]  buf0_nxt;
    logic [3:0]  buf1_nxt;
    logic [2:0]  credit;
    logic        pop;
    logic        full_r;
    logic        afull_r;
    logic        ovfl_r;

    assign q_valid     = (buf_cnt != 2'd0);
    assign q_data      = buf0;
    assign pop         = q_valid & q_ready;
    assign full        = full_r;
    assign almost_full = afull_r;
    assign ovfl_err    = ovfl_r;

    // ram_occ counts committed writes only, so a word is never read in its write cycle
    assign ram_occ  = wr_ptr - rd_ptr;
    assign ram_wren = push & ~full_r & ~reset;
    assign ram_wrad = wr_ptr[9:0];
    assign ram_data = push_data;

    // Entries already owed to the buffer after this cycle's pop must leave room for one more
    assign credit   = {1'b0, buf_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
    assign ram_rden = (ram_occ != 11'd0) & (credit < 3'd2) & ~reset;
    assign ram_rdad = rd_ptr[9:0];

    assign wr_ptr_nxt = wr_ptr + {10'd0, ram_wren};
    assign rd_ptr_nxt = rd_ptr + {10'd0, ram_rden};
    assign occ_nxt    = wr_ptr_nxt - rd_ptr_nxt;

    always_comb begin
        count_nxt = count;
        case ({ram_wren, pop})
            2'b10:   count_nxt = count + 11'd1;
            2'b01:   count_nxt = count - 11'd1;
            default: count_nxt = count;
        endcase
    end

    // Pop shifts the head first; a capture then lands behind whatever remains
    always_comb begin
        buf0_nxt    = buf0;
        buf1_nxt    = buf1;
        buf_cnt_nxt = buf_cnt;
        if (pop) begin
            buf0_nxt    = buf1;
            buf_cnt_nxt = buf_cnt - 2'd1;
        end
        if (rd_inflight) begin
            if (buf_cnt_nxt == 2'd0) begin
                buf0_nxt = ram_q;
            end else begin
                buf1_nxt = ram_q;
            end
            buf_cnt_nxt = buf_cnt_nxt + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= 11'd0;
            rd_ptr      <= 11'd0;
            rd_inflight <= 1'b0;
            buf_cnt     <= 2'd0;
            buf0        <= 4'd0;
            buf1        <= 4'd0;
            full_r      <= 1'b0;
            afull_r     <= 1'b0;
            ovfl_r      <= 1'b0;
            count       <= 11'd0;
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            rd_inflight <= ram_rden;
            buf_cnt     <= buf_cnt_nxt;
            buf0        <= buf0_nxt;
            buf1        <= buf1_nxt;
            full_r      <= (occ_nxt == 11'd1024);
            afull_r     <= (occ_nxt >= AFULL_TH);
            ovfl_r      <= push & full_r;
            count       <= count_nxt;
        end
    end

endmodule

// File: tb/tb_afp3_fifo1024x004_ctl.sv
// tb/tb_afp3_fifo1024x004_ctl.sv - randomized scoreboard bench for afp3_fifo1024x004_ctl
module tb_afp3_fifo1024x004_ctl;

    localparam int THRESH = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        push = 1'b0;
    logic [3:0]  push_data = 4'd0;
    logic        q_ready = 1'b0;
    logic        full;
    logic        almost_full;
    logic        q_valid;
    logic [3:0]  q_data;
    logic [10:0] count;
    logic        ovfl_err;
    logic        ram_wren;
    logic [9:0]  ram_wrad;
    logic [3:0]  ram_data;
    logic        ram_rden;
    logic [9:0]  ram_rdad;
    logic [3:0]  ram_q = 4'd0;

    logic [3:0]  mem [0:1023];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    afp3_fifo1024x004_ctl #(.AFULL_THRESH(THRESH)) dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data),
        .full(full), .almost_full(almost_full), .q_valid(q_valid), .q_data(q_data),
        .q_ready(q_ready), .count(count), .ovfl_err(ovfl_err),
        .ram_wren(ram_wren), .ram_wrad(ram_wrad), .ram_data(ram_data),
        .ram_rden(ram_rden), .ram_rdad(ram_rdad), .ram_q(ram_q)
    );

    // Block RAM: registered read, one cycle latency
    always @(posedge clk) begin
        if (ram_wren) mem[ram_wrad] <= ram_data;
        if (ram_rden) ram_q <= mem[ram_rdad];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model in terms of totals: writes, reads issued, reads landed, pops
    int         m_wr, m_rd, m_cap, m_pop;
    bit         m_ovfl;
    logic [3:0] sb[$];
    bit         prev_stall;
    logic [3:0] prev_qd;

    always @(negedge clk) begin
        int  occ, avail;
        bit  e_full, e_af, e_wren, e_qv, e_pop, e_rden;
        if (reset) begin
            chk("rst_q_valid", q_valid, 0);
            chk("rst_count", count, 0);
            chk("rst_full", full, 0);
            chk("rst_afull", almost_full, 0);
            chk("rst_ovfl", ovfl_err, 0);
            chk("rst_wren", ram_wren, 0);
            chk("rst_rden", ram_rden, 0);
            m_wr = 0; m_rd = 0; m_cap = 0; m_pop = 0; m_ovfl = 0;
            sb.delete();
            prev_stall = 0;
        end else begin
            occ    = m_wr - m_rd;
            avail  = m_cap - m_pop;
            e_full = (occ == 1024);
            e_af   = (occ >= THRESH);
            e_wren = push && !e_full;
            e_qv   = (avail > 0);
            e_pop  = e_qv && q_ready;
            e_rden = (occ != 0) && ((m_rd - m_pop - int'(e_pop)) < 2);
            chk("full", full, int'(e_full));
            chk("almost_full", almost_full, int'(e_af));
            chk("ram_wren", ram_wren, int'(e_wren));
            chk("ram_wrad", ram_wrad, m_wr % 1024);
            if (e_wren) chk("ram_data", ram_data, push_data);
            chk("ram_rden", ram_rden, int'(e_rden));
            if (e_rden) chk("ram_rdad", ram_rdad, m_rd % 1024);
            chk("q_valid", q_valid, int'(e_qv));
            chk("count", count, m_wr - m_pop);
            chk("ovfl_err", ovfl_err, int'(m_ovfl));
            chk("collision", int'(ram_rden && ram_wren && (ram_rdad == ram_wrad)), 0);
            if (e_qv) chk("q_data", q_data, sb[0]);
            if (prev_stall && q_valid) chk("q_data_hold", q_data, prev_qd);
            prev_stall = q_valid && !q_ready;
            prev_qd    = q_data;
            m_ovfl = push && e_full;
            if (e_wren) begin
                sb.push_back(push_data);
                m_wr++;
            end
            if (e_pop) begin
                void'(sb.pop_front());
                m_pop++;
            end
            m_cap = m_rd;
            if (e_rden) m_rd++;
        end
    end

    initial begin
        int first_af, pops, bad, last_pop, burst, cyc;
        logic [3:0] d;

        for (int i = 0; i < 1024; i++) mem[i] = 4'(i * 7);
        tick(); tick();
        @(negedge clk);
        chk("rst_q_data", q_data, 0);

        // 1: single entry latency
        tick();
        reset = 1'b0; push = 1'b1; push_data = 4'hA; q_ready = 1'b1;
        @(negedge clk); chk("t1_wren_c0", ram_wren, 1);
        tick(); push = 1'b0;
        @(negedge clk); chk("t1_rden_c1", ram_rden, 1);
        tick();
        @(negedge clk); chk("t1_qv_c2", q_valid, 0);
        tick();
        @(negedge clk);
        chk("t1_qv_c3", q_valid, 1);
        chk("t1_qd_c3", q_data, 10);
        chk("t1_count_c3", count, 1);
        tick();
        @(negedge clk);
        chk("t1_count_c4", count, 0);
        chk("t1_qv_c4", q_valid, 0);

        // 2: fill with no pops
        tick(); q_ready = 1'b0;
        first_af = -1;
        for (int i = 0; i < 1026; i++) begin
            push = 1'b1; push_data = 4'(i);
            @(negedge clk);
            if (almost_full && first_af < 0) first_af = i;
            tick();
        end
        chk("t2_af_cycle", first_af, 1002);
        push_data = 4'hF;
        @(negedge clk);
        chk("t2_full", full, 1);
        chk("t2_wren_when_full", ram_wren, 0);
        chk("t2_count", count, 1026);
        tick(); push = 1'b0;
        @(negedge clk);
        chk("t2_ovfl_pulse", ovfl_err, 1);
        chk("t2_count_after", count, 1026);
        tick();
        @(negedge clk); chk("t2_ovfl_end", ovfl_err, 0);

        // 3: drain from full
        tick(); q_ready = 1'b1;
        pops = 0; bad = 0; last_pop = -1;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("t3_full_c0", full, 1);
                chk("t3_rden_c0", ram_rden, 1);
            end
            if (c == 1) chk("t3_full_c1", full, 0);
            if (q_valid) begin
                if (q_data != 4'(pops)) bad++;
                pops++;
                last_pop = c;
            end
            tick();
        end
        chk("t3_pops", pops, 1026);
        chk("t3_order_bad", bad, 0);
        chk("t3_last_pop", last_pop, 1025);
        @(negedge clk);
        chk("t3_qv_end", q_valid, 0);
        chk("t3_count_end", count, 0);

        // 4: streaming through several pointer wraps
        tick();
        for (int i = 0; i < 3000; i++) begin
            push = 1'b1; push_data = 4'($urandom);
            if (i == 2000) begin
                @(negedge clk);
                chk("t4_count_steady", count, 3);
            end
            tick();
        end
        push = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        @(negedge clk); chk("t4_count_end", count, 0);

        // 5: random bursts and random back-pressure
        tick();
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            if (burst == 0) burst = int'($urandom_range(1, 20)) * (($urandom % 2 == 0) ? 1 : -1);
            push      = (burst > 0);
            burst     = (burst > 0) ? burst - 1 : burst + 1;
            push_data = 4'($urandom);
            q_ready   = 1'($urandom);
            tick();
        end
        push = 1'b0; q_ready = 1'b1;
        cyc = 0;
        while ((count != 0 || q_valid) && cyc < 1200) begin
            tick();
            cyc++;
        end
        @(negedge clk); chk("t5_drained", count, 0);

        // 6: reset with a read in flight
        tick(); q_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; push_data = 4'(i + 8);
            tick();
        end
        push = 1'b0;
        tick(); tick(); tick();
        q_ready = 1'b1;
        @(negedge clk); chk("t6_rden_pop", ram_rden, 1);
        tick();
        q_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_qv_reset", q_valid, 0);
        chk("t6_count_reset", count, 0);
        tick();
        reset = 1'b0; push = 1'b1; push_data = 4'h3;
        tick(); push = 1'b0;
        tick();
        @(negedge clk); chk("t6_qv_early", q_valid, 0);
        tick();
        @(negedge clk);
        d = q_data;
        chk("t6_qv", q_valid, 1);
        chk("t6_qd", d, 3);
        tick();
        @(negedge clk); chk("t6_count_end", count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
